// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Load/store master between EXU and the data SRAM. Drives AR/R for
//            loads and AW/W/B for stores, extracts/extends load lanes,
//            generates store strobes, returns one response per request.
// Revision : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_load_i,
    input  logic              req_store_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [7:0]        wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    output logic [4:0]        resp_rd_o,
    output logic              resp_err_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_WR   = 3'd3,
        S_B    = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic              w_misaligned;
    logic [DATA_W-1:0] w_rshift;
    logic [DATA_W-1:0] w_ext;
    logic [3:0]        w_strb;

    // Alignment rule: halfwords need addr[0]=0, words need addr[1:0]=0.
    assign w_misaligned =
        (((req_funct3_i == 3'b001) || (req_funct3_i == 3'b101)) && req_addr_i[0]) ||
        ((req_funct3_i == 3'b010) && (req_addr_i[1:0] != 2'b00));

    // Load lane extraction and sign/zero extension of the returning beat.
    always_comb begin
        w_rshift = rdata_i >> {addr_q[1:0], 3'b000};
        w_ext    = w_rshift;
        case (funct3_q)
            3'b000:  w_ext = {{(DATA_W-8){w_rshift[7]}},   w_rshift[7:0]};
            3'b001:  w_ext = {{(DATA_W-16){w_rshift[15]}}, w_rshift[15:0]};
            3'b100:  w_ext = {{(DATA_W-8){1'b0}},          w_rshift[7:0]};
            3'b101:  w_ext = {{(DATA_W-16){1'b0}},         w_rshift[15:0]};
            default: w_ext = w_rshift;
        endcase
    end

    // Store byte strobes from the incoming request size and offset.
    always_comb begin
        case (req_funct3_i[1:0])
            2'b00:   w_strb = 4'b0001 << req_addr_i[1:0];
            2'b01:   w_strb = 4'b0011 << req_addr_i[1:0];
            default: w_strb = 4'b1111;
        endcase
    end

    // Next-state and datapath update for the request sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        data_d    = data_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d    = req_addr_i;
                    funct3_d  = req_funct3_i;
                    rd_d      = req_rd_i;
                    data_d    = '0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wdata_d   = '0;
                    wstrb_d   = 4'b0000;
                    if (!req_load_i && !req_store_i) begin
                        state_d = S_DONE;
                    end else if (w_misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (req_load_i) begin
                        state_d = S_AR;
                    end else begin
                        wdata_d = req_wdata_i << {req_addr_i[1:0], 3'b000};
                        wstrb_d = w_strb;
                        state_d = S_WR;
                    end
                end
            end
            S_AR: begin
                if (arready_i) state_d = S_R;
            end
            S_R: begin
                if (rvalid_i) begin
                    data_d  = w_ext;
                    err_d   = (rresp_i != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_WR: begin
                // AW and W complete independently; leave once both are done.
                if (awready_i) aw_done_d = 1'b1;
                if (wready_i)  w_done_d  = 1'b1;
                if ((aw_done_q || awready_i) && (w_done_q || wready_i)) state_d = S_B;
            end
            S_B: begin
                if (bvalid_i) begin
                    err_d   = (bresp_i != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            funct3_q  <= 3'b000;
            rd_q      <= 5'd0;
            wdata_q   <= '0;
            wstrb_q   <= 4'b0000;
            data_q    <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            data_q    <= data_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Valids/readies decode purely from registered state.
    assign req_ready_o  = (state_q == S_IDLE);
    assign arvalid_o    = (state_q == S_AR);
    assign rready_o     = (state_q == S_R);
    assign awvalid_o    = (state_q == S_WR) && !aw_done_q;
    assign wvalid_o     = (state_q == S_WR) && !w_done_q;
    assign bready_o     = (state_q == S_B);
    assign resp_valid_o = (state_q == S_DONE);

    assign araddr_o    = {addr_q[ADDR_W-1:2], 2'b00};
    assign awaddr_o    = {addr_q[ADDR_W-1:2], 2'b00};
    assign wdata_o     = wdata_q;
    assign wstrb_o     = {4'b0000, wstrb_q};
    assign resp_data_o = data_q;
    assign resp_rd_o   = rd_q;
    assign resp_err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Directed self-checking bench for lsu_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid_i, req_load_i, req_store_i;
    logic        req_ready_o;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic [31:0] araddr_o, awaddr_o, wdata_o, rdata_i, resp_data_o;
    logic        arvalid_o, arready_i, rvalid_i, rready_o;
    logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
    logic [1:0]  rresp_i, bresp_i;
    logic [7:0]  wstrb_o;
    logic        resp_valid_o, resp_ready_i, resp_err_o;
    logic [4:0]  resp_rd_o;

    int checks   = 0;
    int failures = 0;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_load_i(req_load_i), .req_store_i(req_store_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o), .resp_err_o(resp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        req_valid_i = 1'b1; req_load_i = ld; req_store_i = st;
        req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wd; req_rd_i = rd;
        tick();
        req_valid_i = 1'b0; req_load_i = 1'b0; req_store_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid_i = 0; req_load_i = 0; req_store_i = 0; req_funct3_i = 0;
        req_addr_i = 0; req_wdata_i = 0; req_rd_i = 0;
        arready_i = 0; rdata_i = 0; rresp_i = 0; rvalid_i = 0;
        awready_i = 0; wready_i = 0; bresp_i = 0; bvalid_i = 0; resp_ready_i = 0;
        tick(); tick();
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready_o); end
        checks++; if ({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, resp_valid_o} !== 6'b0) begin
            failures++; $display("FAIL rst_valids got=%b exp=000000", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, resp_valid_o}); end
        checks++; if ({araddr_o, awaddr_o, wdata_o, wstrb_o} !== 104'd0) begin
            failures++; $display("FAIL rst_bus got=%h %h %h %h exp=0", araddr_o, awaddr_o, wdata_o, wstrb_o); end
        checks++; if ({resp_data_o, resp_rd_o, resp_err_o} !== 38'd0) begin
            failures++; $display("FAIL rst_resp got=%h %h %b exp=0", resp_data_o, resp_rd_o, resp_err_o); end
        rst = 1'b1;
        tick();
    endtask

    // Loads with arready/rvalid pre-asserted; WBU not ready until 3 edges after acceptance.
    task automatic test_load_ext();
        logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
        logic [31:0] ad  [6] = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000002, 32'h80000001, 32'h80000004};
        logic [31:0] rw  [6] = '{32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233, 32'hDEADBEEF};
        logic [31:0] exd [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011, 32'h00000022, 32'hDEADBEEF};
        logic [31:0] exa [6] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000004};
        for (int i = 0; i < 6; i++) begin
            arready_i = 1'b1; rvalid_i = 1'b1; rdata_i = rw[i]; rresp_i = 2'b00; resp_ready_i = 1'b0;
            issue(1'b1, 1'b0, f3[i], ad[i], 32'h0, 5'(i + 1));
            checks++; if (arvalid_o !== 1'b1 || araddr_o !== exa[i]) begin
                failures++; $display("FAIL ld_ar[%0d] got=%b/%h exp=1/%h", i, arvalid_o, araddr_o, exa[i]); end
            tick();
            checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL ld_early_resp[%0d] got=%b exp=0", i, resp_valid_o); end
            tick(); tick();
            checks++; if (resp_valid_o !== 1'b1 || resp_data_o !== exd[i] || resp_err_o !== 1'b0 || resp_rd_o !== 5'(i + 1)) begin
                failures++; $display("FAIL ld_resp[%0d] got=%b/%h/%b/%0d exp=1/%h/0/%0d", i, resp_valid_o, resp_data_o, resp_err_o, resp_rd_o, exd[i], i + 1); end
            arready_i = 1'b0; rvalid_i = 1'b0;
            resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
            checks++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
                failures++; $display("FAIL ld_back_idle[%0d] got=%b/%b exp=1/0", i, req_ready_o, resp_valid_o); end
        end
    endtask

    // SH with AW completing two cycles ahead of W.
    task automatic test_store_sh();
        issue(1'b0, 1'b1, 3'b001, 32'h80000002, 32'h0000BEEF, 5'd7);
        checks++; if (awvalid_o !== 1'b1 || wvalid_o !== 1'b1 || wstrb_o !== 8'h0C || wdata_o !== 32'hBEEF0000 || awaddr_o !== 32'h80000000) begin
            failures++; $display("FAIL sh_issue got=%b/%b/%h/%h/%h exp=1/1/0c/beef0000/80000000", awvalid_o, wvalid_o, wstrb_o, wdata_o, awaddr_o); end
        awready_i = 1'b1; tick(); awready_i = 1'b0;
        checks++; if (awvalid_o !== 1'b0 || wvalid_o !== 1'b1) begin
            failures++; $display("FAIL sh_aw_done got=%b/%b exp=0/1", awvalid_o, wvalid_o); end
        tick();
        checks++; if (wvalid_o !== 1'b1 || bready_o !== 1'b0) begin
            failures++; $display("FAIL sh_w_wait got=%b/%b exp=1/0", wvalid_o, bready_o); end
        wready_i = 1'b1; tick(); wready_i = 1'b0;
        checks++; if (wvalid_o !== 1'b0 || bready_o !== 1'b1) begin
            failures++; $display("FAIL sh_in_b got=%b/%b exp=0/1", wvalid_o, bready_o); end
        bvalid_i = 1'b1; bresp_i = 2'b00; tick(); bvalid_i = 1'b0;
        checks++; if (resp_valid_o !== 1'b1 || resp_err_o !== 1'b0 || resp_data_o !== 32'h0 || resp_rd_o !== 5'd7) begin
            failures++; $display("FAIL sh_resp got=%b/%b/%h/%0d exp=1/0/0/7", resp_valid_o, resp_err_o, resp_data_o, resp_rd_o); end
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
    endtask

    // SB with AW and W in the same cycle, error write response.
    task automatic test_store_same_cycle();
        awready_i = 1'b1; wready_i = 1'b1;
        issue(1'b0, 1'b1, 3'b000, 32'h80000001, 32'h000000A5, 5'd3);
        checks++; if (wstrb_o !== 8'h02 || wdata_o !== 32'h0000A500 || awvalid_o !== 1'b1 || wvalid_o !== 1'b1) begin
            failures++; $display("FAIL sb_issue got=%h/%h/%b/%b exp=02/0000a500/1/1", wstrb_o, wdata_o, awvalid_o, wvalid_o); end
        tick(); awready_i = 1'b0; wready_i = 1'b0;
        checks++; if (bready_o !== 1'b1 || awvalid_o !== 1'b0 || wvalid_o !== 1'b0) begin
            failures++; $display("FAIL sb_both got=%b/%b/%b exp=1/0/0", bready_o, awvalid_o, wvalid_o); end
        bvalid_i = 1'b1; bresp_i = 2'b10; tick(); bvalid_i = 1'b0; bresp_i = 2'b00;
        checks++; if (resp_valid_o !== 1'b1 || resp_err_o !== 1'b1) begin
            failures++; $display("FAIL sb_bresp_err got=%b/%b exp=1/1", resp_valid_o, resp_err_o); end
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
    endtask

    // SW with W completing before AW.
    task automatic test_store_w_first();
        issue(1'b0, 1'b1, 3'b010, 32'h80000008, 32'h12345678, 5'd4);
        checks++; if (wstrb_o !== 8'h0F || wdata_o !== 32'h12345678 || awaddr_o !== 32'h80000008) begin
            failures++; $display("FAIL sw_issue got=%h/%h/%h exp=0f/12345678/80000008", wstrb_o, wdata_o, awaddr_o); end
        wready_i = 1'b1; tick(); wready_i = 1'b0;
        checks++; if (wvalid_o !== 1'b0 || awvalid_o !== 1'b1 || bready_o !== 1'b0) begin
            failures++; $display("FAIL sw_w_first got=%b/%b/%b exp=0/1/0", wvalid_o, awvalid_o, bready_o); end
        awready_i = 1'b1; tick(); awready_i = 1'b0;
        bvalid_i = 1'b1; tick(); bvalid_i = 1'b0;
        checks++; if (resp_valid_o !== 1'b1 || resp_err_o !== 1'b0) begin
            failures++; $display("FAIL sw_resp got=%b/%b exp=1/0", resp_valid_o, resp_err_o); end
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
    endtask

    // Misaligned accesses and no-op requests complete without bus traffic.
    task automatic test_misaligned();
        issue(1'b1, 1'b0, 3'b010, 32'h80000006, 32'h0, 5'd11);
        checks++; if (arvalid_o !== 1'b0 || resp_valid_o !== 1'b1 || resp_err_o !== 1'b1 || resp_rd_o !== 5'd11) begin
            failures++; $display("FAIL lw_misal got=%b/%b/%b/%0d exp=0/1/1/11", arvalid_o, resp_valid_o, resp_err_o, resp_rd_o); end
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
        issue(1'b0, 1'b1, 3'b001, 32'h80000001, 32'h1234, 5'd12);
        checks++; if (awvalid_o !== 1'b0 || wvalid_o !== 1'b0 || resp_valid_o !== 1'b1 || resp_err_o !== 1'b1) begin
            failures++; $display("FAIL sh_misal got=%b/%b/%b/%b exp=0/0/1/1", awvalid_o, wvalid_o, resp_valid_o, resp_err_o); end
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
        issue(1'b0, 1'b0, 3'b010, 32'h80000001, 32'h0, 5'd13);
        checks++; if (resp_valid_o !== 1'b1 || resp_err_o !== 1'b0 || resp_data_o !== 32'h0 || arvalid_o !== 1'b0) begin
            failures++; $display("FAIL noop got=%b/%b/%h/%b exp=1/0/0/0", resp_valid_o, resp_err_o, resp_data_o, arvalid_o); end
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
    endtask

    // LH with slow arready and a stalled WBU.
    task automatic test_stall();
        issue(1'b1, 1'b0, 3'b001, 32'h80000002, 32'h0, 5'd9);
        for (int k = 0; k < 3; k++) begin
            checks++; if (arvalid_o !== 1'b1 || araddr_o !== 32'h80000000 || req_ready_o !== 1'b0) begin
                failures++; $display("FAIL lh_ar_hold[%0d] got=%b/%h/%b exp=1/80000000/0", k, arvalid_o, araddr_o, req_ready_o); end
            tick();
        end
        arready_i = 1'b1; tick(); arready_i = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'h7FFF0000; tick(); rvalid_i = 1'b0; rdata_i = 32'h0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (resp_valid_o !== 1'b1 || resp_data_o !== 32'h00007FFF || resp_rd_o !== 5'd9 || req_ready_o !== 1'b0) begin
                failures++; $display("FAIL lh_resp_hold[%0d] got=%b/%h/%0d/%b exp=1/00007fff/9/0", k, resp_valid_o, resp_data_o, resp_rd_o, req_ready_o); end
            tick();
        end
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL lh_idle got=%b exp=1", req_ready_o); end
    endtask

    // Error read response, then reset asserted while waiting in R.
    task automatic test_err_and_reset();
        arready_i = 1'b1; rvalid_i = 1'b1; rresp_i = 2'b10; rdata_i = 32'hCAFEF00D;
        issue(1'b1, 1'b0, 3'b010, 32'h80000000, 32'h0, 5'd15);
        tick(); tick();
        checks++; if (resp_valid_o !== 1'b1 || resp_err_o !== 1'b1 || resp_data_o !== 32'hCAFEF00D) begin
            failures++; $display("FAIL lw_rresp got=%b/%b/%h exp=1/1/cafef00d", resp_valid_o, resp_err_o, resp_data_o); end
        rvalid_i = 1'b0; rresp_i = 2'b00;
        resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h80000010, 32'h0, 5'd16);
        tick(); arready_i = 1'b0;
        checks++; if (rready_o !== 1'b1) begin failures++; $display("FAIL rst_pre_r got=%b exp=1", rready_o); end
        #2 rst = 1'b0;
        #1;
        checks++; if (req_ready_o !== 1'b1 || rready_o !== 1'b0 || resp_valid_o !== 1'b0 || araddr_o !== 32'h0 || resp_rd_o !== 5'd0) begin
            failures++; $display("FAIL rst_mid got=%b/%b/%b/%h/%0d exp=1/0/0/0/0", req_ready_o, rready_o, resp_valid_o, araddr_o, resp_rd_o); end
        rst = 1'b1;
        rvalid_i = 1'b1; tick(); rvalid_i = 1'b0;
        checks++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            failures++; $display("FAIL rst_release got=%b/%b exp=1/0", req_ready_o, resp_valid_o); end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_store_sh();
        test_store_same_cycle();
        test_store_w_first();
        test_misaligned();
        test_stall();
        test_err_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
